// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// datapath mux selects and the internal control word.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int unsigned IDLE_CNT_W = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // Per-state control word; pc_update and branch are folded into pc_write at the top.
    typedef struct packed {
        logic        adr_src;
        logic        mem_write;
        logic        ir_write;
        logic        reg_write;
        logic        pc_update;
        logic        branch;
        logic        illegal;
        result_src_t result_src;
        src_a_t      alu_src_a;
        src_b_t      alu_src_b;
        alu_op_t     alu_op;
    } ctrl_t;

    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields onto the ALU control code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output alu_ctrl_t  alu_control
);

    // NOTE: the output gets a default before any branching, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only register-register ops use funct7b5 to select subtract.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with a memory-ready stall handshake and a sticky illegal state.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       illegal_instr
);

    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic [IDLE_CNT_W-1:0] idle_cnt_next;
    ctrl_t                 ctrl;
    alu_ctrl_t             alu_ctrl;
    imm_src_t              imm_sel;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and updates together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            idle_cnt <= '0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        idle_cnt_next = '0;
        case (state)
            S_IDLE: begin
                idle_cnt_next = idle_cnt + 1'b1;
                if (idle_cnt == IDLE_LAST) state_next = S_FETCH;
            end
            S_FETCH: if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECUTER;
                    OP_I:              state_next = S_EXECUTEI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH:         state_next = S_BEQ;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_IDLE;
        endcase
    end

    // Outputs depend on state only, apart from the fetch handshake on mem_ready.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_ILLEGAL: ctrl.illegal = 1'b1;
            default: ;
        endcase
    end

    // The immediate select follows op directly, but is held at zero while idle.
    always_comb begin
        imm_sel = IMM_I;
        if (state != S_IDLE) imm_sel = imm_src_of(op);
    end

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctrl)
    );

    assign pc_write      = ctrl.pc_update | (ctrl.branch & zero);
    assign adr_src       = ctrl.adr_src;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_write     = ctrl.reg_write;
    assign result_src    = ctrl.result_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_control   = alu_ctrl;
    assign imm_src       = imm_sel;
    assign illegal_instr = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: vector table, directed corner
// sequences and random instruction streams against a per-instruction step model.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;
    localparam logic [6:0] ROPS [6]  = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH};

    logic       clk;
    logic       resetn;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       illegal_instr;
    } outs_t;

    typedef struct packed {
        logic  mr;
        outs_t exp;
    } step_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         exp_alu;
        int         exp_len;
    } vec_t;

    outs_t act;
    int    n_tests;
    int    n_failed;
    vec_t  vecs [12];

    assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, alu_control, imm_src, illegal_instr};

    multicycle_ctrl_fsm #(.IDLE_CYCLES(1)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input outs_t got, input outs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic outs_t o(input logic pcw, input logic adr, input logic memw,
                                input logic irw, input logic regw, input logic [1:0] rs,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [2:0] alu, input logic [1:0] imm,
                                input logic ill);
        outs_t r;
        r.pc_write = pcw; r.adr_src = adr; r.mem_write = memw; r.ir_write = irw;
        r.reg_write = regw; r.result_src = rs; r.alu_src_a = a; r.alu_src_b = b;
        r.alu_control = alu; r.imm_src = imm; r.illegal_instr = ill;
        return r;
    endfunction

    function automatic logic [2:0] exp_alu(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'b000:  return (opc[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] opc);
        if (opc == OP_STORE)  return 2'b01;
        if (opc == OP_BRANCH) return 2'b10;
        if (opc == OP_JAL)    return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Builds the expected per-cycle trace of one instruction, then plays it.
    // Starts and ends one time unit after a rising edge, DUT in FETCH.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic z, input int fetch_stall, input int mem_stall,
                             input int play_n, input string tag);
        step_t      q [$];
        logic [1:0] imm;
        int         n;
        imm = exp_imm(opc);
        op = opc; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < fetch_stall; i++)
            q.push_back({1'b0, o(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0)});
        q.push_back({1'b1, o(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0)});
        q.push_back({rnd_bit(), o(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0)});
        case (opc)
            OP_LOAD: begin
                q.push_back({rnd_bit(), o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0)});
                for (int i = 0; i <= mem_stall; i++)
                    q.push_back({(i == mem_stall), o(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0)});
                q.push_back({rnd_bit(), o(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, imm, 0)});
            end
            OP_STORE: begin
                q.push_back({rnd_bit(), o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0)});
                for (int i = 0; i <= mem_stall; i++)
                    q.push_back({(i == mem_stall), o(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0)});
            end
            OP_R, OP_I: begin
                q.push_back({rnd_bit(), o(0, 0, 0, 0, 0, 2'b00, 2'b10, (opc == OP_R) ? 2'b00 : 2'b01,
                                          exp_alu(opc, f3, f7), imm, 0)});
                q.push_back({rnd_bit(), o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0)});
            end
            OP_JAL: begin
                q.push_back({rnd_bit(), o(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 0)});
                q.push_back({rnd_bit(), o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0)});
            end
            OP_BRANCH:
                q.push_back({rnd_bit(), o(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 0)});
            default:
                for (int i = 0; i < 20; i++)
                    q.push_back({rnd_bit(), o(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1)});
        endcase
        n = (play_n < 0) ? q.size() : play_n;
        for (int i = 0; i < n; i++) begin
            mem_ready = q[i].mr;
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), act, q[i].exp);
            @(posedge clk);
            #1;
        end
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, then releases and
    // checks the single idle cycle. Ends one time unit after the edge into FETCH.
    task automatic do_reset(input string tag);
        #1 resetn = 1'b0;
        #1 check({tag, "_async"}, act, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, act, '0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check({tag, "_idle"}, act, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        n_tests  = 0;
        n_failed = 0;
        resetn   = 1'b0;
        op       = '0;
        funct3   = '0;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        mem_ready = 1'b1;

        vecs[0]  = '{OP_R,      3'b000, 1'b0, 0, 4};
        vecs[1]  = '{OP_R,      3'b000, 1'b1, 1, 4};
        vecs[2]  = '{OP_I,      3'b000, 1'b1, 0, 4};
        vecs[3]  = '{OP_R,      3'b010, 1'b0, 5, 4};
        vecs[4]  = '{OP_I,      3'b110, 1'b0, 3, 4};
        vecs[5]  = '{OP_R,      3'b111, 1'b1, 2, 4};
        vecs[6]  = '{OP_I,      3'b001, 1'b0, 0, 4};
        vecs[7]  = '{OP_R,      3'b100, 1'b1, 0, 4};
        vecs[8]  = '{OP_BRANCH, 3'b000, 1'b0, 1, 3};
        vecs[9]  = '{OP_LOAD,   3'b010, 1'b0, 0, 5};
        vecs[10] = '{OP_STORE,  3'b010, 1'b1, 0, 4};
        vecs[11] = '{OP_JAL,    3'b010, 1'b1, 0, 4};

        do_reset("rst0");
        mem_ready = 1'b1;
        @(negedge clk);
        check("fetch_after_reset", act, o(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));

        // Table: from inside a FETCH, check the third-cycle ALU code and the
        // number of cycles until the next FETCH with memory always ready.
        for (int v = 0; v < 12; v++) begin
            op = vecs[v].op; funct3 = vecs[v].f3; funct7b5 = vecs[v].f7;
            c = 1;
            do begin
                @(posedge clk);
                #1;
                @(negedge clk);
                c++;
                if (c == 3) check_int($sformatf("vec%0d_alu", v), int'(alu_control), vecs[v].exp_alu);
            end while (!ir_write && c < 20);
            check_int($sformatf("vec%0d_len", v), c - 1, vecs[v].exp_len);
        end

        do_reset("rst1");
        run_instr(OP_LOAD,   3'b010, 1'b0, 1'b0, 0, 0, -1, "lw");
        run_instr(OP_STORE,  3'b010, 1'b0, 1'b0, 0, 3, -1, "sw_stall3");
        run_instr(OP_R,      3'b000, 1'b1, 1'b0, 0, 0, -1, "sub");
        run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0, -1, "beq_taken");
        run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b0, 0, 0, -1, "beq_not");
        run_instr(OP_JAL,    3'b000, 1'b0, 1'b0, 0, 0, -1, "jal");
        run_instr(OP_LOAD,   3'b010, 1'b0, 1'b1, 2, 2, -1, "lw_stalls");

        // Reset while a store strobe is active must drop it immediately.
        run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 3, 4, "sw_abort");
        #1 check_int("sw_abort_strobe", int'(mem_write), 1);
        do_reset("rst_sw");

        for (int n = 0; n < 150; n++) begin
            run_instr(ROPS[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), rnd_bit(), rnd_bit(),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1,
                      $sformatf("rand%0d", n));
        end

        run_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0, -1, "illegal");
        do_reset("rst_ill");
        run_instr(OP_I, 3'b111, 1'b0, 1'b0, 0, 0, -1, "post_ill");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
